// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : dmem_pkg
//  Purpose : Shared definitions for the data-memory arbiter. Holds the access
//            size codes, the memory write-strobe codes, the arbiter FSM state
//            enum, and helpers for size decoding and alignment checking.
//  Rev     : 1.0  initial release
// ============================================================================
package dmem_pkg;

  // Access size as presented by the requesting ports and on mem_data
  localparam logic [1:0] SIZE_BYTE    = 2'b00;
  localparam logic [1:0] SIZE_HALF    = 2'b01;
  localparam logic [1:0] SIZE_WORD    = 2'b10;
  localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

  // Write strobe encoding on mem_write
  localparam logic [1:0] MW_NONE = 2'b00;
  localparam logic [1:0] MW_BYTE = 2'b01;
  localparam logic [1:0] MW_HALF = 2'b10;
  localparam logic [1:0] MW_WORD = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_e;

  // Size 11, a halfword on an odd address, or a word off a 4-byte boundary
  function automatic logic access_illegal(input logic [1:0] size,
                                          input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    case (size)
      SIZE_HALF:    bad = addr_lo[0];
      SIZE_WORD:    bad = |addr_lo;
      SIZE_ILLEGAL: bad = 1'b1;
      default:      bad = 1'b0;
    endcase
    return bad;
  endfunction

  // Store size to write-strobe code
  function automatic logic [1:0] size_to_mw(input logic [1:0] size);
    logic [1:0] mw;
    mw = MW_NONE;
    case (size)
      SIZE_BYTE: mw = MW_BYTE;
      SIZE_HALF: mw = MW_HALF;
      SIZE_WORD: mw = MW_WORD;
      default:   mw = MW_NONE;
    endcase
    return mw;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
//  Module  : rr_arbiter2
//  Purpose : Two-input round-robin selector (purely combinational).
//  Ports   : req[1:0]  request vector (bit 0 = port A, bit 1 = port B)
//            last      index of the port served most recently (1 = B)
//            gnt[1:0]  one-hot grant, zero when nothing is requested
//  Rev     : 1.0  initial release
// ============================================================================
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      // On a tie the port that was not served last wins
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : dmem_arbiter
//  Purpose : Shares one data memory between port A (pipeline MEM stage) and
//            port B (loader/debug). One access every two cycles:
//            grant (IDLE/RESP) -> ACCESS (memory driven) -> RESP (rvalid).
//  Ports   : clk, rst_n                 clock, async active-low reset
//            x_req/x_we/x_size/x_addr/x_wdata  port request (x = a, b)
//            x_gnt                      request accepted this cycle
//            x_rvalid/x_err/x_rdata     completion pulse, error, load data
//            mem_address/mem_data_in    address and store data to memory
//            mem_write, mem_data        write strobe code, read size
//            mem_data_out               combinational read data from memory
//  Rev     : 1.0  initial release
// ============================================================================
module dmem_arbiter
  import dmem_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [1:0]  a_size,
  input  logic [31:0] a_addr,
  input  logic [31:0] a_wdata,
  output logic        a_gnt,
  output logic        a_rvalid,
  output logic        a_err,
  output logic [31:0] a_rdata,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [1:0]  b_size,
  input  logic [31:0] b_addr,
  input  logic [31:0] b_wdata,
  output logic        b_gnt,
  output logic        b_rvalid,
  output logic        b_err,
  output logic [31:0] b_rdata,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  output logic [1:0]  mem_write,
  output logic [1:0]  mem_data,
  input  logic [31:0] mem_data_out
);

  state_e      state_q, state_d;
  logic        last_q, last_d;     // 1 = port B served most recently
  logic        owner_q, owner_d;   // 1 = port B owns the current access
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] a_rdata_q, a_rdata_d;
  logic [31:0] b_rdata_q, b_rdata_d;
  logic        a_err_q, a_err_d;
  logic        b_err_q, b_err_d;

  logic [1:0]  arb_gnt;
  logic        illegal;
  logic [31:0] capture;

  rr_arbiter2 u_rr (
    .req  ({b_req, a_req}),
    .last (last_q),
    .gnt  (arb_gnt)
  );

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    owner_d     = owner_q;
    we_d        = we_q;
    size_d      = size_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    a_rdata_d   = a_rdata_q;
    b_rdata_d   = b_rdata_q;
    a_err_d     = a_err_q;
    b_err_d     = b_err_q;
    a_gnt       = 1'b0;
    b_gnt       = 1'b0;
    mem_address = 32'd0;
    mem_data_in = 32'd0;
    mem_write   = MW_NONE;
    mem_data    = SIZE_WORD;

    illegal = access_illegal(size_q, addr_q[1:0]);
    // Stores and faulting accesses complete with zero data
    capture = (we_q || illegal) ? 32'd0 : mem_data_out;

    case (state_q)
      ACCESS: begin
        mem_address = addr_q;
        mem_data_in = wdata_q;
        mem_data    = size_q;
        mem_write   = (we_q && !illegal) ? size_to_mw(size_q) : MW_NONE;
        if (owner_q) begin
          b_rdata_d = capture;
          b_err_d   = illegal;
        end else begin
          a_rdata_d = capture;
          a_err_d   = illegal;
        end
        state_d = RESP;
      end
      default: begin
        // IDLE and RESP both accept a new request back-to-back
        if (|arb_gnt) begin
          a_gnt   = arb_gnt[0];
          b_gnt   = arb_gnt[1];
          owner_d = arb_gnt[1];
          last_d  = arb_gnt[1];
          we_d    = arb_gnt[1] ? b_we    : a_we;
          size_d  = arb_gnt[1] ? b_size  : a_size;
          addr_d  = arb_gnt[1] ? b_addr  : a_addr;
          wdata_d = arb_gnt[1] ? b_wdata : a_wdata;
          state_d = ACCESS;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      owner_q   <= 1'b0;
      we_q      <= 1'b0;
      size_q    <= SIZE_WORD;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      a_rdata_q <= 32'd0;
      b_rdata_q <= 32'd0;
      a_err_q   <= 1'b0;
      b_err_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      size_q    <= size_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
      a_err_q   <= a_err_d;
      b_err_q   <= b_err_d;
    end
  end

  assign a_rvalid = (state_q == RESP) && !owner_q;
  assign b_rvalid = (state_q == RESP) &&  owner_q;
  assign a_rdata  = a_rdata_q;
  assign b_rdata  = b_rdata_q;
  assign a_err    = a_err_q;
  assign b_err    = b_err_q;

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 a_req, a_we  input  1 each  port A (pipeline MEM stage) request and write-enable.
REQ-005 a_size  input  2  port A access size: 00 byte, 01 halfword, 10 word, 11 illegal.
REQ-006 a_addr, a_wdata  input  32 each  port A byte address and store data.
REQ-007 a_gnt  output  1  port A request accepted this cycle.
REQ-008 a_rvalid, a_err  output  1 each  port A one-cycle completion pulse and error flag.
REQ-009 a_rdata  output  32  port A load data.
REQ-010 b_* ports SHALL mirror REQ-004..REQ-009 for port B (loader/debug).
REQ-011 mem_address, mem_data_in  output  32 each  to data memory.
REQ-012 mem_write  output  2  00 none, 01 byte, 10 halfword, 11 word.
REQ-013 mem_data  output  2  read size: 00 byte, 01 halfword, 10 word.
REQ-014 mem_data_out  input  32  combinational read data from memory.

Function
REQ-015 SHALL use FSM states IDLE, ACCESS, RESP.
REQ-016 In IDLE or RESP, a requesting port SHALL be granted combinationally (x_gnt=1); the request is latched on that edge and the FSM enters ACCESS.
REQ-017 In ACCESS, x_gnt SHALL be 0 for both ports.
REQ-018 Simultaneous requests SHALL be resolved round-robin: the port not served last wins; last-served SHALL reset to B, so A wins the first tie.
REQ-019 A lone requester SHALL always be granted, regardless of last-served.
REQ-020 In ACCESS, outputs SHALL drive the latched addr/wdata, mem_write = size+1 if we else 00, and mem_data = size.
REQ-021 mem_data_out SHALL be captured into the owner's rdata register at the end of ACCESS; writes SHALL return rdata=0.
REQ-022 Owner's x_rvalid SHALL be 1 for exactly the RESP cycle; latency from grant edge to rvalid is 2 cycles; throughput is one access per 2 cycles.
REQ-023 Misaligned (halfword with addr[0]=1, word with addr[1:0]!=0) or size 11 SHALL be accepted, SHALL NOT write memory (mem_write=00), and SHALL complete with x_err=1, x_rdata=0.
REQ-024 Outside ACCESS, mem_write SHALL be 00, mem_data 10, mem_address and mem_data_in 0.
REQ-025 A port's rdata/err SHALL hold until its next completion; the non-owner's rvalid SHALL stay 0.
REQ-026 From RESP with no request, the FSM SHALL return to IDLE.

Reset
REQ-027 On rst_n=0, state SHALL become IDLE immediately, last-served = B, all rvalid/err = 0, rdata = 0, mem_write = 00.
REQ-028 Reset during ACCESS SHALL abort the access with no memory write and no rvalid.

Structure
REQ-029 Package dmem_pkg SHALL hold size codes, mem_write codes, and the FSM state enum.
REQ-030 Two-input round-robin selection SHALL be sub-module rr_arbiter2 (req[1:0], last, gnt[1:0]).

Verification
REQ-031 A word store 0xDEADBEEF @0x10, then A word load @0x10 -> a_rvalid 2 cycles after each grant; a_rdata=0xDEADBEEF, a_err=0.
REQ-032 A and B request together from reset -> A granted first, B next; grants alternate while both hold req.
REQ-033 B halfword load @0x11 -> b_err=1, b_rdata=0, mem_write stays 00 throughout.
REQ-034 Byte store 0x80 @0x20, byte load @0x20 -> rdata=0xFFFFFF80.
REQ-035 rst_n low in ACCESS of a store -> mem_write 00 immediately, no rvalid, memory unchanged on readback.
